// File: rtl/ppg_pkg.sv
// Shared widths, calc-FSM state codes, snapshot payload and SpO2 mapping for
// the pulse-oximeter ratio extractor. The SpO2 mapping is only used when the
// block is built with SPO2_LUT_EN defined.
package ppg_pkg;

  localparam int unsigned ADC_W     = 8;
  localparam int unsigned RATIO_W   = 10;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned SPO2_W    = 7;
  localparam int unsigned NUM_W     = 24;
  localparam int unsigned DEN_W     = 16;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned STEP_W    = 5;

  localparam logic [RATIO_W-1:0] RATIO_SAT = 10'd1023;

  // Calc FSM state codes
  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_MUL  = 3'd1;
  localparam logic [2:0] C_CHK  = 3'd2;
  localparam logic [2:0] C_DIV  = 3'd3;
  localparam logic [2:0] C_OUT  = 3'd4;

  // SpO2 linear map: 110 - (25*R >> 8), clamped to 0..100
  localparam logic [SPO2_W-1:0] SPO2_OFS   = 7'd110;
  localparam logic [4:0]        SPO2_SLOPE = 5'd25;
  localparam logic [SPO2_W-1:0] SPO2_MAX   = 7'd100;

  // Per-window AC/DC terms captured at the window boundary
  typedef struct packed {
    logic [ADC_W-1:0] ac_r;
    logic [ADC_W-1:0] dc_r;
    logic [ADC_W-1:0] ac_ir;
    logic [ADC_W-1:0] dc_ir;
    logic             seen_r;
    logic             seen_ir;
  } snap_t;

  // Q2.8 ratio to SpO2 percent
  function automatic logic [SPO2_W-1:0] spo2_of(input logic [RATIO_W-1:0] r);
    logic [14:0]       prod;
    logic [SPO2_W-1:0] drop;
    prod = 15'(r) * 15'(SPO2_SLOPE);
    drop = SPO2_W'(prod >> FRAC_BITS);
    if (drop >= SPO2_OFS) begin
      return '0;
    end else if ((SPO2_OFS - drop) > SPO2_MAX) begin
      return SPO2_MAX;
    end else begin
      return SPO2_OFS - drop;
    end
  endfunction

endpackage

// File: rtl/ratio_divider.sv
// Unsigned 24b/16b restoring divider, one quotient bit per cycle.
// start is sampled only while idle; done_c is high during the final step so
// the quotient is stable on the following cycle.
module ratio_divider
  import ppg_pkg::*;
(
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             done_c,
  output logic [NUM_W-1:0] quotient
);

  logic [DEN_W-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]  quo_q, quo_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DEN_W:0]    rem_sh;
  logic [DEN_W:0]    rem_sub;

  // Shift-subtract step and start handling
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    rem_sh  = {rem_q, quo_q[NUM_W-1]};
    rem_sub = rem_sh - {1'b0, divisor};
    if (!busy_q) begin
      if (start) begin
        rem_d  = '0;
        quo_d  = dividend;
        cnt_d  = STEP_W'(NUM_W);
        busy_d = 1'b1;
      end
    end else begin
      if (rem_sh >= {1'b0, divisor}) begin
        rem_d = rem_sub[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - STEP_W'(1);
      if (cnt_q == STEP_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_c   = busy_q && (cnt_q == STEP_W'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/ppg_ratio_extract.sv
// Pulse-oximeter ratio-of-ratios extractor: per-window RED/IR min/max
// tracking, AC/DC snapshot, and R = (ACr*DCir)/(ACir*DCr) in Q2.8.
// Optional macro SPO2_LUT_EN enables the SpO2 estimate; otherwise spo2 stays 0.
module ppg_ratio_extract
  import ppg_pkg::*;
#(
  parameter int unsigned WIN_LEN = 1000
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               en,
  input  logic               led_red,
  input  logic               led_ir,
  input  logic [ADC_W-1:0]   red_adc,
  input  logic [ADC_W-1:0]   ir_adc,
  output logic [RATIO_W-1:0] ratio,
  output logic               ratio_valid,
  output logic               err,
  output logic [SPO2_W-1:0]  spo2
);

  // Window counter, trackers and snapshot
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] r_min_q, r_min_d, r_max_q, r_max_d;
  logic [ADC_W-1:0] i_min_q, i_min_d, i_max_q, i_max_d;
  logic             r_seen_q, r_seen_d, i_seen_q, i_seen_d;
  logic [ADC_W-1:0] r_min_n, r_max_n, i_min_n, i_max_n;
  logic             r_seen_n, i_seen_n;
  logic [ADC_W:0]   r_sum, i_sum;
  logic             take_r, take_ir, win_end;
  snap_t            snap_q, snap_d;

  // Calc FSM and registered outputs
  logic [2:0]         state_q, state_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [DEN_W-1:0]   den_q, den_d;
  logic               bad_q, bad_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic [SPO2_W-1:0]  spo2_q, spo2_d;
  logic               div_start_c;
  logic               div_done_c;
  logic [NUM_W-1:0]   quotient;
  logic [RATIO_W-1:0] q_ratio_c;

  // Sample gating, tracker update, window boundary and snapshot capture
  always_comb begin
    take_r   = en & led_red & ~led_ir;
    take_ir  = en & led_ir & ~led_red;
    win_end  = en && (cnt_q == CNT_W'(WIN_LEN - 1));

    r_min_n  = (take_r && (red_adc < r_min_q)) ? red_adc : r_min_q;
    r_max_n  = (take_r && (red_adc > r_max_q)) ? red_adc : r_max_q;
    r_seen_n = r_seen_q | take_r;
    i_min_n  = (take_ir && (ir_adc < i_min_q)) ? ir_adc : i_min_q;
    i_max_n  = (take_ir && (ir_adc > i_max_q)) ? ir_adc : i_max_q;
    i_seen_n = i_seen_q | take_ir;

    r_sum    = {1'b0, r_max_n} + {1'b0, r_min_n};
    i_sum    = {1'b0, i_max_n} + {1'b0, i_min_n};

    cnt_d    = (!en || win_end) ? '0 : cnt_q + CNT_W'(1);

    if (!en || win_end) begin
      r_min_d  = '1;
      r_max_d  = '0;
      r_seen_d = 1'b0;
      i_min_d  = '1;
      i_max_d  = '0;
      i_seen_d = 1'b0;
    end else begin
      r_min_d  = r_min_n;
      r_max_d  = r_max_n;
      r_seen_d = r_seen_n;
      i_min_d  = i_min_n;
      i_max_d  = i_max_n;
      i_seen_d = i_seen_n;
    end

    snap_d = snap_q;
    if (win_end) begin
      snap_d.ac_r    = r_max_n - r_min_n;
      snap_d.dc_r    = ADC_W'(r_sum >> 1);
      snap_d.ac_ir   = i_max_n - i_min_n;
      snap_d.dc_ir   = ADC_W'(i_sum >> 1);
      snap_d.seen_r  = r_seen_n;
      snap_d.seen_ir = i_seen_n;
    end
  end

  // Acquisition registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      r_min_q  <= '1;
      r_max_q  <= '0;
      r_seen_q <= 1'b0;
      i_min_q  <= '1;
      i_max_q  <= '0;
      i_seen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      r_min_q  <= r_min_d;
      r_max_q  <= r_max_d;
      r_seen_q <= r_seen_d;
      i_min_q  <= i_min_d;
      i_max_q  <= i_max_d;
      i_seen_q <= i_seen_d;
      snap_q   <= snap_d;
    end
  end

  ratio_divider u_div (
    .CLK      (CLK),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (num_q),
    .divisor  (den_q),
    .done_c   (div_done_c),
    .quotient (quotient)
  );

  // Next-state and output logic of the calc FSM
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    den_d       = den_q;
    bad_d       = bad_q;
    ratio_d     = ratio_q;
    err_d       = err_q;
    spo2_d      = spo2_q;
    valid_d     = 1'b0;
    div_start_c = 1'b0;
    q_ratio_c   = (quotient > NUM_W'(RATIO_SAT)) ? RATIO_SAT : quotient[RATIO_W-1:0];

    case (state_q)
      C_IDLE: begin
        if (win_end) begin
          state_d = C_MUL;
        end
      end
      C_MUL: begin
        num_d   = NUM_W'({8'd0, snap_q.ac_r} * {8'd0, snap_q.dc_ir}) << FRAC_BITS;
        den_d   = {8'd0, snap_q.ac_ir} * {8'd0, snap_q.dc_r};
        state_d = C_CHK;
      end
      C_CHK: begin
        if (!snap_q.seen_r || !snap_q.seen_ir ||
            (snap_q.ac_ir == '0) || (snap_q.dc_r == '0)) begin
          bad_d   = 1'b1;
          state_d = C_OUT;
        end else begin
          bad_d       = 1'b0;
          div_start_c = 1'b1;
          state_d     = C_DIV;
        end
      end
      C_DIV: begin
        if (div_done_c) begin
          state_d = C_OUT;
        end
      end
      C_OUT: begin
        valid_d = 1'b1;
        state_d = C_IDLE;
        if (bad_q) begin
          ratio_d = RATIO_SAT;
          err_d   = 1'b1;
          spo2_d  = '0;
        end else begin
          ratio_d = q_ratio_c;
          err_d   = 1'b0;
`ifdef SPO2_LUT_EN
          spo2_d  = spo2_of(q_ratio_c);
`else
          spo2_d  = '0;
`endif
        end
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
  end

  // Calc FSM state and output registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      bad_q   <= 1'b0;
      ratio_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      spo2_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      bad_q   <= bad_d;
      ratio_q <= ratio_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      spo2_q  <= spo2_d;
    end
  end

  assign ratio       = ratio_q;
  assign ratio_valid = valid_q;
  assign err         = err_q;
  assign spo2        = spo2_q;

endmodule

// File: tb/tb_ppg_ratio_extract.sv
// Directed bench for ppg_ratio_extract: expected pulses are queued when a
// window is completed and compared (value and arrival cycle) when the DUT
// raises ratio_valid.
module tb_ppg_ratio_extract;

  logic       CLK = 1'b0;
  logic       rst;
  logic       en;
  logic       led_red;
  logic       led_ir;
  logic [7:0] red_adc;
  logic [7:0] ir_adc;
  logic [9:0] ratio;
  logic       ratio_valid;
  logic       err;
  logic [6:0] spo2;

  typedef struct {
    logic [9:0] ratio;
    logic       err;
    logic [6:0] spo2;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  ppg_ratio_extract #(.WIN_LEN(1000)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .en          (en),
    .led_red     (led_red),
    .led_ir      (led_ir),
    .red_adc     (red_adc),
    .ir_adc      (ir_adc),
    .ratio       (ratio),
    .ratio_valid (ratio_valid),
    .err         (err),
    .spo2        (spo2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] sp(input int v);
`ifdef SPO2_LUT_EN
    return 7'(v);
`else
    return (v == -1) ? 7'd0 : 7'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // One clock; sample #1 after the edge and score any pulse
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      e = exp_q.pop_front();
      check("pulse_missing", 32'(ratio_valid), 32'(1));
    end
    if (ratio_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(ratio_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("ratio",   32'(ratio), 32'(e.ratio));
        check("err",     32'(err),   32'(e.err));
        check("spo2",    32'(spo2),  32'(e.spo2));
        check("latency", 32'(cyc),   32'(e.due));
      end
    end
  endtask

  task automatic push_exp(input logic [9:0] r, input logic e, input logic [6:0] s, input int lat);
    exp_q.push_back('{ratio: r, err: e, spo2: s, due: cyc + lat});
  endtask

  // n enabled cycles; LEDs alternate every 10 cycles (or both on), samples
  // alternate lo/hi, and the unselected ADC carries a decoy value
  task automatic run_window(input int n, input int r_lo, input int r_hi,
                            input int i_lo, input int i_hi, input bit both);
    logic ph;
    for (int i = 0; i < n; i++) begin
      ph = ((i / 10) % 2) == 1;
      en = 1'b1;
      if (both) begin
        led_red = 1'b1;
        led_ir  = 1'b1;
      end else begin
        led_red = !ph;
        led_ir  = ph;
      end
      red_adc = (led_red && !led_ir) ? 8'((i % 2 == 1) ? r_hi : r_lo) : 8'd3;
      ir_adc  = (led_ir && !led_red) ? 8'((i % 2 == 1) ? i_hi : i_lo) : 8'd252;
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en      = 1'b0;
      led_red = 1'b0;
      led_ir  = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; led_red = 1'b0; led_ir = 1'b0;
    red_adc = 8'd0; ir_adc = 8'd0;
    tick(); tick(); tick();
    check("rst_ratio", 32'(ratio), 32'(0));
    check("rst_valid", 32'(ratio_valid), 32'(0));
    check("rst_err",   32'(err), 32'(0));
    check("rst_spo2",  32'(spo2), 32'(0));
    rst = 1'b0;
    idle(2);

    // Normal window: R = 170
    run_window(1000, 100, 140, 90, 150, 1'b0);
    push_exp(10'd170, 1'b0, sp(94), 27);

    // Flat IR: ACir = 0
    run_window(1000, 100, 140, 128, 128, 1'b0);
    push_exp(10'd1023, 1'b1, 7'd0, 3);

    // Large quotient saturates
    run_window(1000, 20, 220, 127, 129, 1'b0);
    push_exp(10'd1023, 1'b0, sp(11), 27);

    // en dropped mid-window, then a full fresh window
    run_window(500, 100, 140, 90, 150, 1'b0);
    idle(20);
    run_window(1000, 100, 140, 90, 150, 1'b0);
    push_exp(10'd170, 1'b0, sp(94), 27);

    // Both LEDs on: neither channel sampled
    run_window(1000, 100, 140, 90, 150, 1'b1);
    push_exp(10'd1023, 1'b1, 7'd0, 3);

    // Reset while dividing: no pulse, outputs cleared
    run_window(1000, 100, 140, 90, 150, 1'b0);
    idle(10);
    rst = 1'b1;
    tick();
    check("midrst_ratio", 32'(ratio), 32'(0));
    check("midrst_valid", 32'(ratio_valid), 32'(0));
    check("midrst_err",   32'(err), 32'(0));
    check("midrst_spo2",  32'(spo2), 32'(0));
    rst = 1'b0;
    idle(40);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
